// File: rtl/f3m_pkg.sv
// Shared definitions for the digit-serial GF(3^M) subtractor:
// field-size default, GF(3) digit constants, controller states, cycle-count helper.
package f3m_pkg;

    localparam int unsigned M_DEF = 593;

    localparam logic [1:0] F3_ZERO = 2'b00;
    localparam logic [1:0] F3_ONE  = 2'b01;
    localparam logic [1:0] F3_TWO  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Element width in bits for an M-digit element (two bits per digit).
    function automatic int unsigned ew(input int unsigned m);
        return 2 * m;
    endfunction

    // Number of D-digit chunks needed to cover M digits.
    function automatic int unsigned ncyc(input int unsigned m, input int unsigned d);
        return (m + d - 1) / d;
    endfunction

endpackage

// File: rtl/f3m_sub_serial_if.sv
// Operand/result handshake bundle for f3m_sub_serial.
// The op signal exists only when F3M_SUB_ADD_MODE_EN is defined.
interface f3m_sub_serial_if
    import f3m_pkg::*;
#(
    parameter int unsigned M = M_DEF
);

    logic               in_valid;
    logic               in_ready;
    logic [ew(M)-1:0]   a;
    logic [ew(M)-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [ew(M)-1:0]   c;
`ifdef F3M_SUB_ADD_MODE_EN
    logic               op;
`endif

    // Producer of operands / consumer of results.
    modport master (
        output in_valid, a, b, out_ready,
`ifdef F3M_SUB_ADD_MODE_EN
        output op,
`endif
        input  in_ready, out_valid, c
    );

    // The subtractor itself.
    modport slave (
        input  in_valid, a, b, out_ready,
`ifdef F3M_SUB_ADD_MODE_EN
        input  op,
`endif
        output in_ready, out_valid, c
    );

endinterface

// File: rtl/f3_digit_op.sv
// One GF(3) digit: o_c = i_a + i_b (i_sub=0) or i_a - i_b (i_sub=1).
// Negation mod 3 is a swap of the two digit bits; any 11 input gives 00.
module f3_digit_op
    import f3m_pkg::*;
(
    input  logic [1:0] i_a,
    input  logic [1:0] i_b,
    input  logic       i_sub,
    output logic [1:0] o_c
);

    logic [1:0] w_b;
    logic [2:0] w_sum;

    // Optional negation of B, then add the two digit values and reduce mod 3.
    always_comb begin
        w_b   = i_sub ? {i_b[0], i_b[1]} : i_b;
        w_sum = {1'b0, i_a} + {1'b0, w_b};
        o_c   = F3_ZERO;
        if ((i_a != 2'b11) && (i_b != 2'b11)) begin
            case (w_sum)
                3'd1, 3'd4: o_c = F3_ONE;
                3'd2:       o_c = F3_TWO;
                default:    o_c = F3_ZERO;
            endcase
        end
    end

endmodule

// File: rtl/f3m_sub_serial.sv
// Digit-serial GF(3^M) subtractor, C = A - B, D digits per clock, NCYC = ceil(M/D) cycles.
// Define F3M_SUB_ADD_MODE_EN to add the op input (1 = A + B), latched with the operands.
module f3m_sub_serial
    import f3m_pkg::*;
#(
    parameter int unsigned M = M_DEF,
    parameter int unsigned D = 8
)(
    input  logic             clk,
    input  logic             reset_n,
    f3m_sub_serial_if.slave  bus
);

    localparam int unsigned EW   = ew(M);
    localparam int unsigned NCYC = ncyc(M, D);
    localparam int unsigned PW   = 2 * D * NCYC;
    localparam int unsigned CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_a;
    logic [PW-1:0]   r_b;
    logic [PW-1:0]   r_c;
    logic [CW-1:0]   r_cnt;
    logic [2*D-1:0]  w_res;
    logic            w_sub;
    logic            w_last;

`ifdef F3M_SUB_ADD_MODE_EN
    logic            r_op;
    assign w_sub = ~r_op;
`else
    assign w_sub = 1'b1;
`endif

    assign w_last = (r_cnt == CW'(NCYC - 1));
    assign bus.c  = r_c[EW-1:0];

    for (genvar g = 0; g < D; g++) begin : g_dig
        f3_digit_op u_dig (
            .i_a   (r_a[2*g +: 2]),
            .i_b   (r_b[2*g +: 2]),
            .i_sub (w_sub),
            .o_c   (w_res[2*g +: 2])
        );
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) w_state_nxt = RUN;
            end
            RUN: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand capture and chunk shifting. Results enter at the top of r_c, so
    // after NCYC shifts chunk 0 sits at the bottom and the padding chunk above EW.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_c   <= '0;
            r_cnt <= '0;
`ifdef F3M_SUB_ADD_MODE_EN
            r_op  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a   <= PW'(bus.a);
                        r_b   <= PW'(bus.b);
                        r_cnt <= '0;
`ifdef F3M_SUB_ADD_MODE_EN
                        r_op  <= bus.op;
`endif
                    end
                end
                RUN: begin
                    r_a   <= r_a >> (2 * D);
                    r_b   <= r_b >> (2 * D);
                    r_c   <= PW'({w_res, r_c} >> (2 * D));
                    r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_f3m_sub_serial.sv
// Scoreboard bench for f3m_sub_serial: a 593-digit/D=8 instance and a 5-digit/D=2 instance.
// Stimulus pushes expected results; negedge monitors compare whenever out_valid is high.
module tb_f3m_sub_serial;
    import f3m_pkg::*;

    localparam int unsigned M   = 593;
    localparam int unsigned D   = 8;
    localparam int unsigned NC  = ncyc(M, D);
    localparam int unsigned EW  = ew(M);
    localparam int unsigned M5  = 5;
    localparam int unsigned D5  = 2;
    localparam int unsigned NC5 = ncyc(M5, D5);

    typedef struct {
        logic [EW-1:0] c;
        int unsigned   acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    f3m_sub_serial_if #(.M(M))  bus  ();
    f3m_sub_serial_if #(.M(M5)) bus5 ();

    f3m_sub_serial #(.M(M), .D(D)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    f3m_sub_serial #(.M(M5), .D(D5)) dut5 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus5)
    );

    exp_t        q[$];
    exp_t        q5[$];
    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    int unsigned cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk1(input string nm, input logic act, input logic req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", nm, act, req);
        end
    endtask

    task automatic chki(input string nm, input int unsigned act, input int unsigned req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", nm, act, req);
        end
    endtask

    task automatic chkw(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] req);
        int idx;
        n_chk++;
        if (act !== req) begin
            n_fail++;
            idx = -1;
            for (int i = 0; i < int'(M); i++) begin
                if (act[2*i +: 2] !== req[2*i +: 2]) begin
                    idx = i;
                    break;
                end
            end
            $display("FAIL %s: first differing digit %0d got %b want %b", nm, idx,
                     act[2*idx +: 2], req[2*idx +: 2]);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
    endtask

    // Reference digit arithmetic on integer values; 11 in either operand yields 0.
    function automatic logic [EW-1:0] model(input logic [EW-1:0] a, input logic [EW-1:0] b,
                                            input logic add);
        logic [EW-1:0] r;
        int            av, bv, s;
        r = '0;
        for (int i = 0; i < int'(M); i++) begin
            av = int'(a[2*i +: 2]);
            bv = int'(b[2*i +: 2]);
            if (av != 3 && bv != 3) begin
                s = add ? (av + bv) : (av - bv + 3);
                r[2*i +: 2] = 2'(s % 3);
            end
        end
        return r;
    endfunction

    // Monitor for the 593-digit instance.
    logic pv = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            pv = 1'b0;
        end else begin
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    timeout("unexpected_out_valid");
                end else begin
                    if (!pv) chki("latency", cyc - q[0].acc, NC);
                    chkw("c", bus.c, q[0].c);
                    chk1("in_ready_in_done", bus.in_ready, 1'b0);
                    if (bus.out_ready) void'(q.pop_front());
                end
            end
            pv = bus.out_valid;
        end
    end

    // Monitor for the 5-digit instance.
    logic pv5 = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            pv5 = 1'b0;
        end else begin
            if (bus5.out_valid) begin
                if (q5.size() == 0) begin
                    timeout("unexpected_out_valid_m5");
                end else begin
                    if (!pv5) chki("latency_m5", cyc - q5[0].acc, NC5);
                    chkw("c_m5", EW'(bus5.c), q5[0].c);
                    if (bus5.out_ready) void'(q5.pop_front());
                end
            end
            pv5 = bus5.out_valid;
        end
    end

    task automatic send(input logic [EW-1:0] a, input logic [EW-1:0] b, input logic op,
                        input logic [EW-1:0] e);
        int unsigned n = 0;
        while (!bus.in_ready && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) timeout("in_ready_wait");
        bus.a = a;
        bus.b = b;
`ifdef F3M_SUB_ADD_MODE_EN
        bus.op = op;
`else
        if (op) $display("note: op ignored without add mode");
`endif
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        q.push_back('{c: e, acc: cyc});
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((q.size() != 0 || q5.size() != 0) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() != 0 || q5.size() != 0) timeout("drain");
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [EW-1:0] a01, b10, a10, b01, ar, e, am, bm;
        logic [9:0]    a5, b5;
        int unsigned   n;

        a01 = {M{2'b01}};
        b10 = {M{2'b10}};
        a10 = {M{2'b10}};
        b01 = {M{2'b01}};

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        bus5.in_valid = 1'b0;
        bus5.a        = '0;
        bus5.b        = '0;
        bus5.out_ready = 1'b1;
`ifdef F3M_SUB_ADD_MODE_EN
        bus.op  = 1'b0;
        bus5.op = 1'b0;
`endif

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_in_ready", bus.in_ready, 1'b1);
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chkw("rst_c", bus.c, '0);
        chk1("rst_in_ready_m5", bus5.in_ready, 1'b1);
        chk1("rst_out_valid_m5", bus5.out_valid, 1'b0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 1 - 2 = 2 in every digit, with latency check in the monitor.
        send(a01, b10, 1'b0, b10);
        drain();

        // a == b gives zero.
        ar = '0;
        for (int i = 0; i < int'(M); i++) ar[2*i +: 2] = 2'($urandom_range(0, 2));
        send(ar, ar, 1'b0, '0);
        drain();

        // 0 - 1 in digit 0 only, on both instances.
        e = '0;
        e[1:0] = 2'b10;
        send('0, EW'(1), 1'b0, e);
        a5 = '0;
        b5 = 10'd1;
        bus5.a = a5;
        bus5.b = b5;
        bus5.in_valid = 1'b1;
        @(posedge clk); #1;
        bus5.in_valid = 1'b0;
        q5.push_back('{c: EW'(10'b10), acc: cyc});
        drain();

        // Illegal 11 digits force zero in that position.
        am = a10;
        bm = '0;
        am[2*5 +: 2]   = 2'b11;
        bm[2*7 +: 2]   = 2'b11;
        bm[2*592 +: 2] = 2'b01;
        e = a10;
        e[2*5 +: 2]   = 2'b00;
        e[2*7 +: 2]   = 2'b00;
        e[2*592 +: 2] = 2'b01;
        send(am, bm, 1'b0, e);
        drain();

        // Result held while the consumer stalls; in_valid pulses in DONE are ignored.
        bus.out_ready = 1'b0;
        send(a10, b01, 1'b0, b01);
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.out_valid) timeout("out_valid_wait");
        for (int i = 0; i < 10; i++) begin
            bus.a = a01;
            bus.b = '0;
            bus.in_valid = i[0];
            @(posedge clk); #1;
            chk1("hold_out_valid", bus.out_valid, 1'b1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain();
        chk1("idle_after_hold", bus.in_ready, 1'b1);

        // Reset mid-RUN discards the operation; a following operation still completes.
        am = '0;
        bm = '0;
        for (int i = 0; i < int'(M); i++) begin
            am[2*i +: 2] = 2'(i % 3);
            bm[2*i +: 2] = 2'((i * 7 / 3) % 4);
        end
        send(a01, b10, 1'b0, b10);
        repeat (29) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk1("midrun_rst_in_ready", bus.in_ready, 1'b1);
        chk1("midrun_rst_out_valid", bus.out_valid, 1'b0);
        chkw("midrun_rst_c", bus.c, '0);
        q.delete();
        reset_n = 1'b1;
        @(posedge clk); #1;
        send(am, bm, 1'b0, model(am, bm, 1'b0));
        drain();

`ifdef F3M_SUB_ADD_MODE_EN
        // Add mode: 1 + 2 = 0; subtract mode on the same operands gives 2.
        send(a01, b10, 1'b1, '0);
        drain();
        send(a01, b10, 1'b0, b10);
        drain();
        send(am, bm, 1'b1, model(am, bm, 1'b1));
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
